rom_sample_player: RTL and testbench
====================================

# rom_sample_player

Sequencer for one playback channel of the shared sample ROM. Walks a sample index from 0 to a programmed length at a fixed audio rate and drives that index to the ROM round-robin arbiter's per-channel `AccessIndex` input. After a settle window it captures the returned 8-bit sample from the arbiter's `DataOutput`, re-centres and scales it, and presents a signed 16-bit sample with a one-cycle valid strobe to the audio mixer. One instance per ROM client: song 0, song 1, and bee.

## Interface
Parameters:
- CLK_DIV, 6250: clock cycles per sample period (50 MHz / 8 kHz); must be ≥ SETTLE_CYCLES+2.
- SETTLE_CYCLES, 12: cycles from index change to data capture. Covers two 5-slot arbiter rounds plus the ROM read latency.

Ports:
- CLK_50Mhz  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begin playback at index 0.
- stop  in  1  one-cycle pulse; abort playback.
- pause  in  1  level; freezes playback while high.
- loopEnable  in  1  level; wrap to index 0 at end instead of finishing.
- sampleLength  in  16  sample count, latched on start.
- volume  in  4  gain 0..15.
- accessIndex  out  16  index to the arbiter channel.
- dataIn  in  16  arbiter DataOutput; only bits [7:0] are used.
- sampleOut  out  16  signed scaled sample.
- sampleValid  out  1  one-cycle strobe when sampleOut updates.
- busy  out  1  high in RUN or PAUSED.
- done  out  1  one-cycle pulse on natural end of a non-looping play.

## Operation
- States: IDLE, RUN, PAUSED.
- Reset values: state IDLE, accessIndex 0, divCnt 0, lenReg 0, sampleOut 0, sampleValid 0, busy 0, done 0.
- IDLE:
  - start with sampleLength≠0 → RUN, lenReg←sampleLength, accessIndex←0, divCnt←0.
  - start with sampleLength=0 is ignored.
- RUN:
  - divCnt counts 0..CLK_DIV-1.
  - At divCnt==SETTLE_CYCLES: sampleOut←scale(dataIn[7:0]) and sampleValid pulses.
  - At divCnt==CLK_DIV-1: divCnt←0.
    - If accessIndex<lenReg-1: accessIndex+1.
    - Else with loopEnable: accessIndex←0.
    - Else: → IDLE, done pulses, sampleOut←0, accessIndex←0.
- pause high in RUN → PAUSED. divCnt, accessIndex and sampleOut are held; no strobes are issued.
- pause low in PAUSED → RUN, continuing from the held divCnt.
- stop in any state → IDLE, sampleOut←0, accessIndex←0, no done pulse.
- Priority on the same edge: stop > start > pause. start in RUN or PAUSED restarts from index 0 and re-latches sampleLength.
- Scale: s = {1'b0,d} − 128 (signed 9-bit). sampleOut = sign-extend(s × volume) <<< 3, range −15360..+15240.
- Reset asserted mid-play forces all reset values immediately, independent of the clock.

## Timing
- start sampled at edge k → accessIndex=0 and busy=1 after edge k.
- First sampleValid is high in the cycle after edge k+SETTLE_CYCLES.
- Subsequent strobes are exactly CLK_DIV cycles apart, including across a loop wrap.
- accessIndex changes only when divCnt wraps, so it is stable for CLK_DIV cycles.
- done is coincident with busy falling: one cycle after the final period ends.
- Each pause-high cycle extends the current period by one cycle.

## Configuration
- SAMPLE_PLAYER_VOLUME_EN defined: volume scaling as above.
- Not defined: the volume port is unused, sampleOut = sign-extend(s) <<< 7 (range −16384..+16256), and the multiplier is not synthesised.

## Structure
- Package musicbox_audio_pkg holds:
  - the player_state_t enum {IDLE, RUN, PAUSED};
  - SAMPLE_W=16;
  - SAMPLE_MIDPOINT=128;
  - VOLUME_W=4.
- One combinational sub-module, sample_scaler: 8-bit unsigned plus volume in, signed 16-bit out. It carries the SAMPLE_PLAYER_VOLUME_EN switch.

## Test plan
All scenarios use CLK_DIV=20, SETTLE_CYCLES=12.
- Reset then idle: all outputs 0 for 100 cycles; dataIn toggling has no effect.
- start, sampleLength=3, volume=15, dataIn=0xFF, loopEnable=0 → accessIndex 0,1,2 with 20 cycles each. Three strobes with sampleOut=15240, the first in the cycle after edge k+12. done pulses once; sampleOut returns to 0.
- Same with loopEnable=1 and dataIn=0x00 → accessIndex 0,1,2,0,1; sampleOut=−15360; strobes every 20 cycles; no done.
- pause high for 7 cycles at divCnt=5 → that strobe is delayed by exactly 7 cycles; accessIndex is held.
- stop and start asserted on the same edge during RUN → IDLE, busy=0, no done. start alone on the next cycle restarts at index 0.
- start with sampleLength=0 → stays IDLE. Asserting reset_n low mid-play → outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/musicbox_audio_pkg.sv
// Shared types and constants for the ROM sample playback channels.
// Pure declarations; no logic, latency or flow control.
package musicbox_audio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } player_state_t;

  localparam int SAMPLE_W        = 16;
  localparam int SAMPLE_MIDPOINT = 128;
  localparam int VOLUME_W        = 4;

endpackage

// File: rtl/sample_scaler.sv
// Re-centres an unsigned 8-bit ROM sample and scales it to signed 16 bits; combinational, no backpressure.
// SAMPLE_PLAYER_VOLUME_EN selects (s*volume)<<<3; otherwise s<<<7 and volume is ignored.
module sample_scaler
  import musicbox_audio_pkg::*;
(
  input  logic [7:0]                 sample_raw,
  input  logic [VOLUME_W-1:0]        volume,
  output logic signed [SAMPLE_W-1:0] sample_scaled
);

  logic signed [8:0] centred;

  // Wraps modulo 512, so reinterpreting the difference as signed gives -128..127.
  assign centred = signed'({1'b0, sample_raw} - 9'(SAMPLE_MIDPOINT));

`ifdef SAMPLE_PLAYER_VOLUME_EN
  logic signed [13:0] product;

  assign product       = centred * signed'({1'b0, volume});
  assign sample_scaled = SAMPLE_W'(product) <<< 3;
`else
  logic unused_volume;

  assign unused_volume = ^volume;
  assign sample_scaled = SAMPLE_W'(centred) <<< 7;
`endif

endmodule

// File: rtl/rom_sample_player.sv
// One ROM playback channel: steps accessIndex once per CLK_DIV cycles and strobes a scaled sample SETTLE_CYCLES into each period.
// No backpressure from the mixer; pause freezes the period counter. Scaling mode follows SAMPLE_PLAYER_VOLUME_EN.
module rom_sample_player
  import musicbox_audio_pkg::*;
#(
  parameter int CLK_DIV       = 6250,
  parameter int SETTLE_CYCLES = 12
) (
  input  logic                       CLK_50Mhz,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       pause,
  input  logic                       loopEnable,
  input  logic [15:0]                sampleLength,
  input  logic [VOLUME_W-1:0]        volume,
  output logic [15:0]                accessIndex,
  input  logic [15:0]                dataIn,
  output logic signed [SAMPLE_W-1:0] sampleOut,
  output logic                       sampleValid,
  output logic                       busy,
  output logic                       done
);

  localparam int               DIV_W       = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] SETTLE_PREV = DIV_W'(SETTLE_CYCLES - 1);

  player_state_t               state_q, state_d;
  logic [DIV_W-1:0]            div_q, div_d;
  logic [15:0]                 len_q, len_d;
  logic [15:0]                 index_q, index_d;
  logic signed [SAMPLE_W-1:0]  sample_q, sample_d;
  logic                        valid_q, valid_d;
  logic                        done_q, done_d;

  logic signed [SAMPLE_W-1:0]  scaled;
  logic [7:0]                  unused_data_hi;
  logic                        start_ok;
  logic                        more_samples;

  assign unused_data_hi = dataIn[15:8];
  assign start_ok       = start && (sampleLength != 16'd0);
  assign more_samples   = ({1'b0, index_q} + 17'd1) < {1'b0, len_q};

  sample_scaler u_scaler (
    .sample_raw    (dataIn[7:0]),
    .volume        (volume),
    .sample_scaled (scaled)
  );

  always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      len_q    <= '0;
      index_q  <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      len_q    <= len_d;
      index_q  <= index_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    len_d    = len_q;
    index_d  = index_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;

    if (stop) begin
      state_d  = IDLE;
      div_d    = '0;
      index_d  = '0;
      sample_d = '0;
    end else if (start_ok) begin
      state_d = RUN;
      len_d   = sampleLength;
      index_d = '0;
      div_d   = '0;
    end else if (state_q != IDLE) begin
      if (pause) begin
        state_d = PAUSED;
      end else begin
        // Un-pausing edge advances too, so each paused cycle costs exactly one cycle.
        state_d = RUN;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (more_samples) begin
            index_d = index_q + 16'd1;
          end else if (loopEnable) begin
            index_d = '0;
          end else begin
            state_d  = IDLE;
            done_d   = 1'b1;
            sample_d = '0;
            index_d  = '0;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
          if (div_q == SETTLE_PREV) begin
            sample_d = scaled;
            valid_d  = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    busy        = (state_q != IDLE);
    accessIndex = index_q;
    sampleOut   = sample_q;
    sampleValid = valid_q;
    done        = done_q;
  end

endmodule

// File: tb/tb_rom_sample_player.sv
// Directed bench for rom_sample_player with CLK_DIV=20, SETTLE_CYCLES=12.
// Expected sample values follow the SAMPLE_PLAYER_VOLUME_EN setting of the build.
module tb_rom_sample_player;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic        pause;
  logic        loop_en;
  logic [15:0] sample_len;
  logic [3:0]  volume;
  logic [15:0] access_index;
  logic [15:0] data_in;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        done;

  int n_tests;
  int n_fail;

  rom_sample_player #(
    .CLK_DIV       (20),
    .SETTLE_CYCLES (12)
  ) dut (
    .CLK_50Mhz    (clk),
    .reset_n      (reset_n),
    .start        (start),
    .stop         (stop),
    .pause        (pause),
    .loopEnable   (loop_en),
    .sampleLength (sample_len),
    .volume       (volume),
    .accessIndex  (access_index),
    .dataIn       (data_in),
    .sampleOut    (sample_out),
    .sampleValid  (sample_valid),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are observed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_sample(input int d);
`ifdef SAMPLE_PLAYER_VOLUME_EN
    return (d - 128) * int'(volume) * 8;
`else
    return (d - 128) * 128;
`endif
  endfunction

  function automatic int sout();
    return int'($signed(sample_out));
  endfunction

  // Starts a play and checks every cycle j after the start edge for n cycles.
  task automatic run_play(input string tag, input int len, input bit lp, input int d, input int n);
    int period_end;
    int p;
    int e_idx;
    int e_valid;
    int e_done;
    int e_busy;
    int e_out;
    loop_en    = lp;
    sample_len = 16'(len);
    data_in    = 16'(d);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    period_end = len * 20;
    for (int j = 0; j < n; j++) begin
      p = j / 20;
      if (lp || j < period_end) begin
        e_idx  = lp ? (p % len) : p;
        e_busy = 1;
        e_valid = (j % 20 == 12) ? 1 : 0;
        e_out  = (j >= 12) ? exp_sample(d) : 0;
      end else begin
        e_idx   = 0;
        e_busy  = 0;
        e_valid = 0;
        e_out   = 0;
      end
      e_done = (!lp && j == period_end) ? 1 : 0;
      check($sformatf("%s_idx_j%0d", tag, j), int'(access_index), e_idx);
      check($sformatf("%s_valid_j%0d", tag, j), int'(sample_valid), e_valid);
      check($sformatf("%s_done_j%0d", tag, j), int'(done), e_done);
      check($sformatf("%s_busy_j%0d", tag, j), int'(busy), e_busy);
      check($sformatf("%s_out_j%0d", tag, j), sout(), e_out);
      tick();
    end
  endtask

  int noise_hits;
  int exp_pause;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    pause      = 1'b0;
    loop_en    = 1'b0;
    sample_len = 16'd0;
    volume     = 4'd15;
    data_in    = 16'h0000;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    check("rst_idx", int'(access_index), 0);
    check("rst_out", sout(), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);

    noise_hits = 0;
    for (int i = 0; i < 100; i++) begin
      data_in = (i % 2 == 0) ? 16'hFFFF : 16'h5A00;
      tick();
      if (access_index != 16'd0 || sample_out != 16'd0 || sample_valid || busy || done)
        noise_hits++;
    end
    check("idle_quiet", noise_hits, 0);

    // Non-looping: 0xFF -> +16256 (or +15240 with volume 15 when scaling is enabled).
    run_play("once", 3, 1'b0, 8'hFF, 66);

    // Looping: 0x00 -> -16384 (or -15360 with volume), indices 0,1,2,0,1.
    run_play("loop", 3, 1'b1, 8'h00, 100);

    // stop wins over start on the same edge.
    stop  = 1'b1;
    start = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    check("stopstart_busy", int'(busy), 0);
    check("stopstart_done", int'(done), 0);
    check("stopstart_idx", int'(access_index), 0);
    check("stopstart_out", sout(), 0);
    tick();
    check("after_stop_done", int'(done), 0);

    // Fresh start, then pause 7 cycles at divCnt=5.
    data_in = 16'h00FF;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("restart_busy", int'(busy), 1);
    check("restart_idx", int'(access_index), 0);
    repeat (5) tick();
    pause = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("pause_idx_%0d", i), int'(access_index), 0);
      check($sformatf("pause_valid_%0d", i), int'(sample_valid), 0);
      check($sformatf("pause_busy_%0d", i), int'(busy), 1);
    end
    pause = 1'b0;
    exp_pause = exp_sample(8'hFF);
    for (int j = 13; j <= 30; j++) begin
      tick();
      check($sformatf("resume_valid_j%0d", j), int'(sample_valid), (j == 19) ? 1 : 0);
      check($sformatf("resume_idx_j%0d", j), int'(access_index), (j >= 27) ? 1 : 0);
      check($sformatf("resume_out_j%0d", j), sout(), (j >= 19) ? exp_pause : 0);
    end

    // Zero-length start is ignored.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", int'(busy), 0);
    sample_len = 16'd0;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    check("zero_len_busy", int'(busy), 0);
    repeat (15) tick();
    check("zero_len_valid", int'(sample_valid), 0);
    check("zero_len_idx", int'(access_index), 0);

    // Asynchronous reset mid-play, between clock edges.
    sample_len = 16'd3;
    loop_en    = 1'b0;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    repeat (25) tick();
    check("pre_arst_idx", int'(access_index), 1);
    check("pre_arst_out", sout(), exp_pause);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_idx", int'(access_index), 0);
    check("arst_out", sout(), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_valid", int'(sample_valid), 0);
    check("arst_done", int'(done), 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_arst_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
